// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg -- shared constants and types for the demux_4_buf block.
//   NUM_CH : number of output channels
//   SEL_W  : width of the channel select
//   CNT_W  : width of each per-channel transfer counter (DEMUX_CNT_EN builds)
// Also provides the slot state encoding and a select-to-one-hot helper.
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 16;

  // One-entry slot occupancy.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Decode a channel index into a one-hot channel mask.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask      = {NUM_CH{1'b0}};
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot -- single-channel one-entry buffer with valid/ready handshake.
// Optional transfer counter when DEMUX_CNT_EN is defined.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : load data_i this cycle (only asserted when the slot can take it)
//   data_i      : word to load
//   ready_i     : consumer takes the held word this cycle
//   valid_o     : slot holds a word
//   data_o      : held word (last value retained when empty)
//   cnt_o       : output-transfer count, wraps (DEMUX_CNT_EN only)
// -----------------------------------------------------------------------------
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pop_s;

  // Next-state and data-load logic for the one-entry slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop_s   = (state_q == SLOT_FULL) & ready_i;
    case (state_q)
      SLOT_EMPTY: begin
        if (push_i) begin
          state_d = SLOT_FULL;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        // A push in the same cycle as a pop keeps the slot full (no bubble).
        if (push_i) begin
          state_d = SLOT_FULL;
        end else if (ready_i) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
    // Data only changes on a load, so a stalled or emptied slot keeps its word.
    if (push_i) begin
      data_d = data_i;
    end else begin
      data_d = data_q;
    end
  end

  // Slot state and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter next value: one step per output transfer, natural wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_4_buf.sv
// -----------------------------------------------------------------------------
// demux_4_buf -- routes one input word per cycle to one of four buffered
// output channels selected by in_sel. Each channel is an independent one-entry
// slot, so a stalled channel never blocks pushes to the others.
// Optional feature: define DEMUX_CNT_EN to add the out_cnt port with four
// 16-bit per-channel output-transfer counters (channel k at [k*16 +: 16]).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_data     : word to distribute          in_sel   : destination channel
//   in_valid    : in_data/in_sel qualifier    in_ready : word accepted this cycle
//   out_data    : channel k at [k*WIDTH +: WIDTH]
//   out_valid   : per-channel word-present    out_ready: per-channel consumer take
//   out_cnt     : per-channel transfer counters (DEMUX_CNT_EN only)
// -----------------------------------------------------------------------------
module demux_4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] out_cnt
`endif
);

  logic [NUM_CH-1:0] push_s;

  // Accept when the selected slot is empty or is being drained this cycle.
  always_comb begin
    in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    push_s   = sel_onehot(in_sel) & {NUM_CH{in_valid & in_ready}};
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_CNT_EN
      ,
      .cnt_o   (out_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_demux_4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_4_buf -- self-checking bench for demux_4_buf.
// A behavioural model (per-channel occupancy/content/count) tracks what the
// outputs must be; a compare process checks the DUT every cycle. Random
// traffic tags each word with channel and sequence number so per-channel order
// and completeness are checked from the data seen at the outputs.
// -----------------------------------------------------------------------------
module tb_demux_4_buf;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
`ifdef DEMUX_CNT_EN
  logic [63:0]   out_cnt;
`endif

  demux_4_buf #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic          mdl_valid [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [W-1:0]  mdl_data  [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [15:0]   mdl_cnt   [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  int            push_seq  [4] = '{0, 0, 0, 0};
  int            pop_seq   [4] = '{0, 0, 0, 0};
  bit            chk_en = 1'b0;
  bit            ord_en = 1'b0;

  task automatic chk(input string nm, input int ch, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, ch, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] tag(input int ch, input int seq);
    return (32'(ch) << 24) | (32'(seq) & 32'h0000_FFFF);
  endfunction

  // Model: a slot takes a word when empty or being drained; a drained slot
  // without a new word becomes empty; content stays at the last word loaded.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          mdl_valid[k] = 1'b0;
          mdl_data[k]  = '0;
          mdl_cnt[k]   = '0;
        end
      end else begin
        bit acc;
        acc = in_valid && (!mdl_valid[in_sel] || out_ready[in_sel]);
        for (int k = 0; k < 4; k++) begin
          bit taken;
          taken = mdl_valid[k] && out_ready[k];
          if (taken) mdl_cnt[k] = mdl_cnt[k] + 16'd1;
          if (acc && (int'(in_sel) == k)) begin
            mdl_valid[k] = 1'b1;
            mdl_data[k]  = in_data;
            push_seq[k]  = push_seq[k] + 1;
          end else if (taken) begin
            mdl_valid[k] = 1'b0;
          end
        end
      end
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", int'(in_sel), {63'd0, in_ready},
            {63'd0, (!mdl_valid[in_sel] || out_ready[in_sel])});
        for (int k = 0; k < 4; k++) begin
          chk("out_valid", k, {63'd0, out_valid[k]}, {63'd0, mdl_valid[k]});
          chk("out_data", k, {32'd0, out_data[k*W +: W]}, {32'd0, mdl_data[k]});
`ifdef DEMUX_CNT_EN
          chk("out_cnt", k, {48'd0, out_cnt[k*16 +: 16]}, {48'd0, mdl_cnt[k]});
`endif
          if (ord_en && out_valid[k] && out_ready[k]) begin
            chk("order", k, {32'd0, out_data[k*W +: W]}, {32'd0, tag(k, pop_seq[k])});
            pop_seq[k] = pop_seq[k] + 1;
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] sel, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #1;
    chk("rst_valid", -1, {60'd0, out_valid}, 64'd0);
    chk("rst_data_nz", -1, {63'd0, |out_data}, 64'd0);
    chk("rst_in_ready", -1, {63'd0, in_ready}, 64'd1);
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Stalled channel-2 word is held.
    push_one(2'd2, 32'hDEADBEEF);
    chk("s2_valid", 2, {60'd0, out_valid}, 64'h4);
    chk("s2_data", 2, {32'd0, out_data[95:64]}, 64'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_hold_valid", i, {60'd0, out_valid}, 64'h4);
      chk("s2_hold_data", i, {32'd0, out_data[95:64]}, 64'hDEADBEEF);
    end

    // Full stalled channel refuses; other channel still accepts.
    push_one(2'd1, 32'h11111111);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h22222222;
    #1;
    chk("blk_in_ready", 1, {63'd0, in_ready}, 64'd0);
    tick();
    chk("blk_valid", 1, {60'd0, out_valid}, 64'h6);
    chk("blk_data", 1, {32'd0, out_data[63:32]}, 64'h11111111);
    in_sel = 2'd3; in_data = 32'h33333333;
    #1;
    chk("oth_in_ready", 3, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk("oth_valid", 3, {60'd0, out_valid}, 64'hE);
    chk("oth_data", 3, {32'd0, out_data[127:96]}, 64'h33333333);

    // Simultaneous pop and push on channel 0: no bubble.
    push_one(2'd0, 32'h1);
    out_ready = 4'b0001;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h2;
    #1;
    chk("bb_in_ready", 0, {63'd0, in_ready}, 64'd1);
    chk("bb_first", 0, {32'd0, out_data[31:0]}, 64'h1);
    tick();
    in_valid = 1'b0;
    chk("bb_valid", 0, {63'd0, out_valid[0]}, 64'd1);
    chk("bb_second", 0, {32'd0, out_data[31:0]}, 64'h2);
    tick();
    out_ready = 4'b0000;
    chk("bb_drained", 0, {60'd0, out_valid}, 64'hE);

    // Reset mid-operation with all channels full.
    push_one(2'd0, 32'hAAAA0000);
    chk("full_all", -1, {60'd0, out_valid}, 64'hF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h55555555;
    #1;
    chk("arst_valid", -1, {60'd0, out_valid}, 64'd0);
    chk("arst_data_nz", -1, {63'd0, |out_data}, 64'd0);
    chk("arst_in_ready", -1, {63'd0, in_ready}, 64'd1);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    chk("post_rst_valid", -1, {60'd0, out_valid}, 64'd0);
    chk("post_rst_data_nz", -1, {63'd0, |out_data}, 64'd0);

    // Random traffic with per-channel sequence tags.
    #2;
    for (int k = 0; k < 4; k++) begin
      push_seq[k] = 0;
      pop_seq[k]  = 0;
    end
    ord_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      int s;
      s         = int'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'(s);
      in_data   = tag(s, push_seq[s]);
      out_ready = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    tick();
    tick();
    chk("drain_valid", -1, {60'd0, out_valid}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_count", k, 64'(pop_seq[k]), 64'(push_seq[k]));
    end
    ord_en = 1'b0;
    out_ready = 4'h0;

`ifdef DEMUX_CNT_EN
    // 65537 transfers on channel 3: counter wraps to 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    out_ready = 4'b1000;
    for (int i = 0; i < 65537; i++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    chk("cnt_wrap", 3, out_cnt, 64'h0001_0000_0000_0000);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_4_buf.md
DEMUX_4_BUF -- requirements
Module: demux_4_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, which sets the data width of the input and of each output channel.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port in_data, input, WIDTH bits, the word to distribute.
REQ-005 SHALL have port in_sel, input, 2 bits, the destination channel index 0..3.
REQ-006 SHALL have port in_valid, input, 1 bit, which qualifies in_data and in_sel.
REQ-007 SHALL have port in_ready, output, 1 bit; the block accepts the word this cycle.
REQ-008 SHALL have port out_data, output, 4*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port out_valid, output, 4 bits, one per channel; channel k holds a word.
REQ-010 SHALL have port out_ready, input, 4 bits, one per channel; the consumer of channel k takes the word.
REQ-011 SHALL have port out_cnt, output, 64 bits, four 16-bit counters; the port is present only under DEMUX_CNT_EN.

Function
REQ-012 SHALL give each channel a one-entry slot with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-013 SHALL drive in_ready combinationally as ~out_valid[in_sel] | out_ready[in_sel].
REQ-014 SHALL treat an input transfer as in_valid & in_ready; on a transfer, slot[in_sel] loads in_data and is FULL on the next cycle (1-cycle latency).
REQ-015 SHALL treat an output transfer on channel k as out_valid[k] & out_ready[k]; slot k goes FULL->EMPTY unless it is reloaded in the same cycle.
REQ-016 SHALL, when slot k is popped and pushed in the same cycle, take the new word, keep out_valid[k]=1 with no bubble, and neither lose nor duplicate a word.
REQ-017 SHALL hold out_data for channel k stable while out_valid[k] & ~out_ready[k].
REQ-018 SHALL make channels independent: one push plus up to four pops are allowed in the same cycle, and a stalled channel never blocks pushes to other channels.
REQ-019 SHALL leave all state unchanged when in_valid=0 or in_ready=0; in_sel and in_data are then don't-care.
REQ-020 SHALL keep out_data of an EMPTY slot at its last value; out_data content is meaningful only when out_valid is 1.

Reset
REQ-021 SHALL, on rst_n low, immediately clear out_valid to 4'b0000, out_data to all zeros and out_cnt to all zeros, with no clock needed.
REQ-022 SHALL discard any words held at reset assertion, even mid-operation, and SHALL NOT let them reappear after release.
REQ-023 SHALL let in_ready follow REQ-013 during reset, giving in_ready=1 while all slots are EMPTY, and SHALL accept no transfer until the first rising clk edge after rst_n goes high.

Configuration
REQ-024 SHALL implement out_cnt only when macro DEMUX_CNT_EN is defined.
REQ-025 SHALL, with DEMUX_CNT_EN defined, increment counter k on every output transfer on channel k, wrapping 16'hFFFF->16'h0000.
REQ-026 SHALL, without DEMUX_CNT_EN, have no out_cnt port and no counter logic, with all other behaviour identical.

Structure
REQ-027 SHALL place the constants NUM_CH=4, SEL_W=2 and CNT_W=16 in shared package demux_pkg.
REQ-028 SHALL implement one sub-module, demux_slot, as a single-channel one-entry buffer with valid/ready handshake and an optional counter, instantiated four times.

Verification
REQ-029 Bench SHALL cover this scenario: push 32'hDEADBEEF with sel=2 while out_ready=0 -> next cycle out_valid=4'b0100, channel-2 data = DEADBEEF, and it is held for 5 stalled cycles.
REQ-030 Bench SHALL cover this scenario: channel 1 FULL, out_ready[1]=0, push sel=1 -> in_ready=0 and no state change; push sel=3 in the same condition -> accepted.
REQ-031 Bench SHALL cover this scenario: channel 0 FULL with 32'h1, out_ready[0]=1, push 32'h2 with sel=0 in the same cycle -> consumer sees 1 then 2 on back-to-back cycles, with out_valid[0] staying 1.
REQ-032 Bench SHALL cover this scenario: fill all 4 channels, then assert rst_n=0 between clock edges -> out_valid=0 and out_data=0 immediately, and no old word appears after release.
REQ-033 Bench SHALL cover this scenario, with DEMUX_CNT_EN defined: 65537 transfers on channel 3 -> counter 3 = 1 and the other counters = 0.
REQ-034 Bench SHALL cover this scenario: random in_sel, in_valid and out_ready for 10k cycles checked against a scoreboard -> per-channel order is preserved and no word is lost or duplicated.
